pulse_burst_gen: RTL and testbench

PULSE_BURST_GEN -- requirements
Module: pulse_burst_gen

---
 rtl/pulse_burst_pkg.sv | 19 +
 rtl/pulse_gap_timer.sv | 47 ++++
 rtl/pulse_burst_gen.sv | 149 ++++++++++++++
 tb/tb_pulse_burst_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_burst_pkg.sv
// Shared definitions for the pulse burst generator.
// Holds the burst FSM state encoding and the default widths used by
// pulse_burst_gen and its gap timer.
// Optional feature macro used by this codebase slice: PULSE_BURST_ABORT_EN.
package pulse_burst_pkg;

   // Default widths for the burst length / remaining count and the gap timer.
   localparam int DEFAULT_CNT_W = 7;
   localparam int DEFAULT_GAP_W = 16;

   // Burst sequencer states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2,
      DONE  = 2'd3
   } burst_state_e;

endpackage

// File: rtl/pulse_gap_timer.sv
// Down-counter that times the low cycles between strobes.
// Ports:
//   clk      - clock, all logic on posedge
//   rst      - synchronous active-high reset
//   load     - load load_val into the counter (has priority over enable)
//   enable   - count down by one this cycle
//   load_val - number of gap cycles to time, GAP_W bits
//   expire   - high in the final cycle of the timed gap
// The counter holds the number of gap cycles still to go, including the
// current one, so expire fires when it reads 1. This keeps the full
// GAP_W range usable: a load of all-ones times exactly 2^GAP_W-1 cycles.
module pulse_gap_timer #(
   parameter int GAP_W = pulse_burst_pkg::DEFAULT_GAP_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             enable,
   input  logic [GAP_W-1:0] load_val,
   output logic             expire
);

   logic [GAP_W-1:0] cnt_q;
   logic [GAP_W-1:0] cnt_d;

   // Next count: load wins, otherwise decrement while enabled, saturating at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (enable && (cnt_q != '0)) begin
         cnt_d = cnt_q - GAP_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == GAP_W'(1));

endmodule

// File: rtl/pulse_burst_gen.sv
// Pulse burst generator: on an accepted start it emits num single-cycle
// count strobes separated by gap low cycles, then a single-cycle done pulse.
// Ports:
//   clk       - clock, all logic on posedge
//   rst       - synchronous active-high reset
//   abort     - (only with PULSE_BURST_ABORT_EN) cut the burst short
//   start     - burst request, accepted only in IDLE
//   num       - strobes in the burst, latched on accept
//   gap       - low cycles between strobes, latched on accept
//   count     - registered single-cycle strobe
//   busy      - registered, high in PULSE, GAP and DONE
//   done      - registered single-cycle completion pulse
//   remaining - strobes not yet emitted in the current burst
// Macro PULSE_BURST_ABORT_EN adds the abort input.
module pulse_burst_gen
   import pulse_burst_pkg::*;
#(
   parameter int CNT_W = DEFAULT_CNT_W,
   parameter int GAP_W = DEFAULT_GAP_W
) (
   input  logic             clk,
   input  logic             rst,
`ifdef PULSE_BURST_ABORT_EN
   input  logic             abort,
`endif
   input  logic             start,
   input  logic [CNT_W-1:0] num,
   input  logic [GAP_W-1:0] gap,
   output logic             count,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] remaining
);

   burst_state_e     state_q;
   burst_state_e     state_d;
   logic [CNT_W-1:0] remaining_q;
   logic [CNT_W-1:0] remaining_d;
   logic [GAP_W-1:0] gap_q;
   logic [GAP_W-1:0] gap_d;
   logic             count_q;
   logic             busy_q;
   logic             done_q;
   logic             abort_req;
   logic             tmr_load;
   logic             tmr_enable;
   logic             tmr_expire;

`ifdef PULSE_BURST_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   // The timer runs only while sitting in GAP; it is loaded on the PULSE->GAP step.
   assign tmr_enable = (state_q == GAP);

   pulse_gap_timer #(
      .GAP_W (GAP_W)
   ) u_gap_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .enable   (tmr_enable),
      .load_val (gap_q),
      .expire   (tmr_expire)
   );

   // Next-state logic. remaining is decremented on the edge that enters
   // PULSE, so during each strobe cycle it already excludes that strobe
   // and reads 0 during the last one.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      gap_d       = gap_q;
      tmr_load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               gap_d = gap;
               if (num == '0) begin
                  state_d     = DONE;
                  remaining_d = '0;
               end else begin
                  state_d     = PULSE;
                  remaining_d = num - CNT_W'(1);
               end
            end
         end
         PULSE: begin
            if (abort_req) begin
               state_d     = DONE;
               remaining_d = '0;
            end else if (remaining_q == '0) begin
               state_d = DONE;
            end else if (gap_q == '0) begin
               state_d     = PULSE;
               remaining_d = remaining_q - CNT_W'(1);
            end else begin
               state_d  = GAP;
               tmr_load = 1'b1;
            end
         end
         GAP: begin
            if (abort_req) begin
               state_d     = DONE;
               remaining_d = '0;
            end else if (tmr_expire) begin
               state_d     = PULSE;
               remaining_d = remaining_q - CNT_W'(1);
            end
         end
         DONE: begin
            state_d     = IDLE;
            remaining_d = '0;
         end
         default: begin
            state_d     = IDLE;
            remaining_d = '0;
         end
      endcase
   end

   // State and output registers; the outputs are decoded from the next
   // state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         gap_q       <= '0;
         count_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         gap_q       <= gap_d;
         count_q     <= (state_d == PULSE);
         busy_q      <= (state_d != IDLE);
         done_q      <= (state_d == DONE);
      end
   end

   assign count     = count_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign remaining = remaining_q;

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Directed self-checking bench for pulse_burst_gen.
// Runs with a narrow GAP_W so the all-ones gap case stays short.
// With PULSE_BURST_ABORT_EN defined it also exercises the abort input.
module tb_pulse_burst_gen;

   localparam int CNT_W = 7;
   localparam int GAP_W = 4;

   logic             clk;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] num;
   logic [GAP_W-1:0] gap;
   logic             count;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] remaining;
`ifdef PULSE_BURST_ABORT_EN
   logic             abort;
`endif

   int checks   = 0;
   int failures = 0;
   int dec_digit = 0;
   int dec_carries = 0;

   pulse_burst_gen #(
      .CNT_W (CNT_W),
      .GAP_W (GAP_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef PULSE_BURST_ABORT_EN
      .abort     (abort),
`endif
      .start     (start),
      .num       (num),
      .gap       (gap),
      .count     (count),
      .busy      (busy),
      .done      (done),
      .remaining (remaining)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Downstream decade counter fed by the count strobe; counts carries out of 9.
   always @(posedge clk) begin
      if (count) begin
         if (dec_digit == 9) begin
            dec_digit = 0;
            dec_carries = dec_carries + 1;
         end else begin
            dec_digit = dec_digit + 1;
         end
      end
   end

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic s, input int n, input int g);
      start = s;
      num   = CNT_W'(n);
      gap   = GAP_W'(g);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag, input logic c, input logic b,
                           input logic d, input int r);
      checkOutput({tag, ".count"}, 32'(count), 32'(c));
      checkOutput({tag, ".busy"}, 32'(busy), 32'(b));
      checkOutput({tag, ".done"}, 32'(done), 32'(d));
      checkOutput({tag, ".remaining"}, 32'(remaining), 32'(r));
   endtask

   initial begin
      int rem;
      rst = 1'b1;
      applyStimulus(1'b0, 0, 0);
`ifdef PULSE_BURST_ABORT_EN
      abort = 1'b0;
`endif

      // Reset state.
      tick();
      tick();
      checkAll("reset", 1'b0, 1'b0, 1'b0, 0);
      rst = 1'b0;
      tick();
      checkAll("idle", 1'b0, 1'b0, 1'b0, 0);

      // num=10 gap=0: ten back-to-back strobes, done at T+11, one decade carry.
      applyStimulus(1'b1, 10, 0);
      tick();
      for (int k = 1; k <= 10; k++) begin
         checkAll($sformatf("n10.c%0d", k), 1'b1, 1'b1, 1'b0, 10 - k);
         start = 1'b0;
         tick();
      end
      checkAll("n10.done", 1'b0, 1'b1, 1'b1, 0);
      tick();
      checkAll("n10.idle", 1'b0, 1'b0, 1'b0, 0);
      checkOutput("n10.carries", 32'(dec_carries), 32'd1);
      checkOutput("n10.digit", 32'(dec_digit), 32'd0);

      // num=3 gap=2: strobes at T+1, T+4, T+7; done at T+8.
      applyStimulus(1'b1, 3, 2);
      tick();
      start = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         rem = (c < 4) ? 2 : (c < 7) ? 1 : 0;
         checkAll($sformatf("n3g2.c%0d", c), (c == 1 || c == 4 || c == 7),
                  (c <= 8), (c == 8), rem);
         tick();
      end

      // num=0: done and busy for one cycle, no strobe.
      applyStimulus(1'b1, 0, 1);
      tick();
      start = 1'b0;
      checkAll("n0.c1", 1'b0, 1'b1, 1'b1, 0);
      tick();
      checkAll("n0.c2", 1'b0, 1'b0, 1'b0, 0);

      // num=5 gap=1 with a second start at T+3 that must be ignored.
      applyStimulus(1'b1, 5, 1);
      tick();
      for (int c = 1; c <= 11; c++) begin
         start = (c == 3);
         rem = 5 - (((c + 1) / 2 > 5) ? 5 : (c + 1) / 2);
         checkAll($sformatf("n5g1.c%0d", c), ((c % 2) == 1) && (c <= 9),
                  (c <= 10), (c == 10), rem);
         tick();
      end
      start = 1'b0;

      // num=8 gap=0, reset at T+4 together with a start; new burst afterwards.
      applyStimulus(1'b1, 8, 0);
      tick();
      start = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         checkAll($sformatf("rst.c%0d", c), 1'b1, 1'b1, 1'b0, 8 - c);
         if (c == 4) begin
            rst   = 1'b1;
            start = 1'b1;
         end
         tick();
      end
      rst   = 1'b0;
      start = 1'b0;
      checkAll("rst.c5", 1'b0, 1'b0, 1'b0, 0);
      applyStimulus(1'b1, 2, 0);
      tick();
      start = 1'b0;
      checkAll("rst.c6", 1'b1, 1'b1, 1'b0, 1);
      tick();
      checkAll("rst.c7", 1'b1, 1'b1, 1'b0, 0);
      tick();
      checkAll("rst.c8", 1'b0, 1'b1, 1'b1, 0);
      tick();
      checkAll("rst.c9", 1'b0, 1'b0, 1'b0, 0);

      // start held high: re-accepted in the cycle after DONE.
      applyStimulus(1'b1, 1, 0);
      tick();
      checkAll("hold.c1", 1'b1, 1'b1, 1'b0, 0);
      tick();
      checkAll("hold.c2", 1'b0, 1'b1, 1'b1, 0);
      tick();
      checkAll("hold.c3", 1'b0, 1'b0, 1'b0, 0);
      tick();
      start = 1'b0;
      checkAll("hold.c4", 1'b1, 1'b1, 1'b0, 0);
      tick();
      checkAll("hold.c5", 1'b0, 1'b1, 1'b1, 0);
      tick();
      checkAll("hold.c6", 1'b0, 1'b0, 1'b0, 0);

      // Largest gap (all ones): strobes at T+1 and T+17, done at T+18.
      applyStimulus(1'b1, 2, 15);
      tick();
      start = 1'b0;
      for (int c = 1; c <= 19; c++) begin
         checkAll($sformatf("gmax.c%0d", c), (c == 1 || c == 17), (c <= 18),
                  (c == 18), (c < 17) ? 1 : 0);
         tick();
      end

`ifdef PULSE_BURST_ABORT_EN
      // abort in IDLE is ignored.
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkAll("abt.idle", 1'b0, 1'b0, 1'b0, 0);

      // num=6 gap=3, abort in the first cycle of the second gap (T+6).
      applyStimulus(1'b1, 6, 3);
      tick();
      start = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         checkAll($sformatf("abt.c%0d", c), (c == 1 || c == 5), 1'b1, 1'b0,
                  (c < 5) ? 5 : 4);
         abort = (c == 6);
         tick();
      end
      abort = 1'b0;
      checkAll("abt.done", 1'b0, 1'b1, 1'b1, 0);
      tick();
      checkAll("abt.idle2", 1'b0, 1'b0, 1'b0, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
